// File: rtl/dm_cache_ctrl_if.sv
// rtl/dm_cache_ctrl_if.sv - CPU request port and Ram-side port of the cache controller
interface dm_cache_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic             cpu_req;
  logic             cpu_we;
  logic [DEPTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_done;
  logic             cpu_hit;
  logic             cpu_error;
  logic             cpu_busy;
  logic [DEPTH-1:0] mem_adress;
  logic [WIDTH-1:0] mem_data_in;
  logic             mem_write_enable;
  logic             mem_read_enable;
  logic [WIDTH-1:0] mem_data_out;
  logic             mem_valid_out;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_out, mem_valid_out,
    input  cpu_rdata, cpu_done, cpu_hit, cpu_error, cpu_busy,
    input  mem_adress, mem_data_in, mem_write_enable, mem_read_enable
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_out, mem_valid_out,
    output cpu_rdata, cpu_done, cpu_hit, cpu_error, cpu_busy,
    output mem_adress, mem_data_in, mem_write_enable, mem_read_enable
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped, write-through, no-write-allocate cache controller
// One word per line; read misses fill the line, writes always go through to Ram.
module dm_cache_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int INDEX_BITS = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic           clk,
  input  logic           reset,
  dm_cache_ctrl_if.slave bus
);
  localparam int TAG_BITS = DEPTH - INDEX_BITS;
  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int CNT_BITS = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WR_MEM, RD_REQ, RD_WAIT, RESP} state_t;
  state_t state, state_next;

  logic [DEPTH-1:0]    addr_q;
  logic                we_q;
  logic [WIDTH-1:0]    wdata_q;
  logic                wr_hit_q;
  logic [LINES-1:0]    line_valid;
  logic [TAG_BITS-1:0] line_tag  [LINES];
  logic [WIDTH-1:0]    line_data [LINES];
  logic [CNT_BITS-1:0] wait_cnt;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  fill;
  logic                  timed_out;

  assign idx       = addr_q[INDEX_BITS-1:0];
  assign tag       = addr_q[DEPTH-1:INDEX_BITS];
  assign hit       = line_valid[idx] && (line_tag[idx] == tag);
  assign fill      = (state == RD_WAIT) && bus.mem_valid_out;
  // Counter holds the number of idle RD_WAIT cycles already spent; this edge makes it TIMEOUT.
  assign timed_out = (state == RD_WAIT) && !bus.mem_valid_out &&
                     (wait_cnt == CNT_BITS'(TIMEOUT - 1));
  assign bus.cpu_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next           = state;
    bus.mem_write_enable = 1'b0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_adress       = '0;
    bus.mem_data_in      = '0;
    case (state)
      IDLE:    if (bus.cpu_req) state_next = LOOKUP;
      LOOKUP: begin
        if (we_q)     state_next = WR_MEM;
        else if (hit) state_next = RESP;
        else          state_next = RD_REQ;
      end
      WR_MEM: begin
        bus.mem_write_enable = 1'b1;
        bus.mem_adress       = addr_q;
        bus.mem_data_in      = wdata_q;
        state_next           = RESP;
      end
      RD_REQ: begin
        bus.mem_read_enable = 1'b1;
        bus.mem_adress      = addr_q;
        state_next          = RD_WAIT;
      end
      RD_WAIT: begin
        bus.mem_read_enable = 1'b1;
        bus.mem_adress      = addr_q;
        if (fill || timed_out) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      wr_hit_q      <= 1'b0;
      line_valid    <= '0;
      wait_cnt      <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_hit   <= 1'b0;
      bus.cpu_error <= 1'b0;
    end else begin
      // Done follows RESP by one edge so every access completes on a registered pulse.
      bus.cpu_done <= (state == RESP);
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            we_q    <= bus.cpu_we;
            wdata_q <= bus.cpu_wdata;
          end
        end
        LOOKUP: begin
          if (we_q) begin
            wr_hit_q <= hit;
          end else if (hit) begin
            bus.cpu_rdata <= line_data[idx];
            bus.cpu_hit   <= 1'b1;
            bus.cpu_error <= 1'b0;
          end
        end
        WR_MEM: begin
          bus.cpu_hit   <= wr_hit_q;
          bus.cpu_error <= 1'b0;
        end
        RD_REQ: wait_cnt <= '0;
        RD_WAIT: begin
          if (fill) begin
            line_valid[idx] <= 1'b1;
            bus.cpu_rdata   <= bus.mem_data_out;
            bus.cpu_hit     <= 1'b0;
            bus.cpu_error   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timed_out) begin
              bus.cpu_hit   <= 1'b0;
              bus.cpu_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOOKUP && we_q && hit) line_data[idx] <= wdata_q;
    if (fill) begin
      line_tag[idx]  <= tag;
      line_data[idx] <= bus.mem_data_out;
    end
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - self-checking bench for dm_cache_ctrl
// Uses a 1-cycle Ram model and an array-based reference cache.
module tb_dm_cache_ctrl;
  localparam int WIDTH = 32, DEPTH = 4, INDEX_BITS = 2, TIMEOUT = 15;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic        ok;
    logic        noise;
  } stim_t;

  typedef struct packed {
    logic [7:0]  lat;
    logic        hit;
    logic        err;
    logic [31:0] rdata;
    logic        rd_issued;
    logic [3:0]  raddr;
    logic [3:0]  wr_cnt;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        re_resp;
    logic        dbl;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  dm_cache_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  dm_cache_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INDEX_BITS(INDEX_BITS), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] ram [16];
  bit          ram_ok = 1'b1;
  bit          ram_loaded = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_valid_out <= 1'b0;
      bus.mem_data_out  <= '0;
      if (!ram_loaded) begin
        for (int i = 0; i < 16; i++) ram[i] <= 32'hD00D_0000 + 32'(i) * 32'h0101_0011;
        ram_loaded <= 1'b1;
      end
    end else begin
      if (bus.mem_write_enable) ram[bus.mem_adress] <= bus.mem_data_in;
      bus.mem_valid_out <= bus.mem_read_enable && ram_ok;
      bus.mem_data_out  <= ram[bus.mem_adress];
    end
  end

  logic [31:0] ref_mem [16];
  bit          ref_valid [4];
  int          ref_tag [4];
  logic [31:0] ref_data [4];
  logic [31:0] ref_rdata;

  function automatic stim_t mk(logic we, logic [3:0] a, logic [31:0] d, logic ok, logic noise);
    return {we, a, d, ok, noise};
  endfunction

  function automatic string fmt(res_t r);
    return $sformatf("lat=%0d hit=%b err=%b rdata=%h rd=%b@%0d wr=%0d@%0d:%h resp_re=%b dbl=%b",
                     r.lat, r.hit, r.err, r.rdata, r.rd_issued, r.raddr, r.wr_cnt, r.waddr,
                     r.wdata, r.re_resp, r.dbl);
  endfunction

  task automatic model_access(input stim_t s, output res_t e);
    int idx = int'(s.addr) % 4;
    int tg  = int'(s.addr) / 4;
    bit h   = ref_valid[idx] && (ref_tag[idx] == tg);
    e = '0;
    if (s.we) begin
      e.lat = 8'd3; e.hit = h; e.wr_cnt = 4'd1; e.waddr = s.addr; e.wdata = s.wd;
      if (h) ref_data[idx] = s.wd;
      ref_mem[s.addr] = s.wd;
    end else if (h) begin
      e.lat = 8'd2; e.hit = 1'b1;
      ref_rdata = ref_data[idx];
    end else begin
      e.rd_issued = 1'b1; e.raddr = s.addr;
      if (s.ok) begin
        e.lat = 8'd4;
        ref_rdata = ref_mem[s.addr];
        ref_valid[idx] = 1'b1; ref_tag[idx] = tg; ref_data[idx] = ref_mem[s.addr];
      end else begin
        e.lat = 8'(3 + TIMEOUT); e.err = 1'b1;
      end
    end
    e.rdata = ref_rdata;
  endtask

  task automatic run_access(input stim_t s, output res_t o);
    int lat = 0;
    bit done = 0;
    bit prev_re = 0;
    o = '0;
    @(negedge clk);
    ram_ok = s.ok;
    bus.cpu_req = 1'b1; bus.cpu_we = s.we; bus.cpu_addr = s.addr; bus.cpu_wdata = s.wd;
    @(posedge clk);
    @(negedge clk);
    if (s.noise) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom);
      bus.cpu_addr = 4'($urandom); bus.cpu_wdata = $urandom;
    end else begin
      bus.cpu_req = 1'b0;
    end
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.cpu_done) begin
        done = 1; o.re_resp = prev_re;
        o.hit = bus.cpu_hit; o.err = bus.cpu_error; o.rdata = bus.cpu_rdata;
      end else begin
        if (bus.mem_write_enable) begin
          o.wr_cnt++; o.waddr = bus.mem_adress; o.wdata = bus.mem_data_in;
        end
        if (bus.mem_read_enable) begin
          o.rd_issued = 1'b1; o.raddr = bus.mem_adress;
        end
        prev_re = bus.mem_read_enable;
      end
      if (lat == 1) bus.cpu_req = 1'b0;
    end
    o.lat = done ? 8'(lat) : 8'hFF;
    @(negedge clk);
    o.dbl = bus.cpu_done;
  endtask

  task automatic do_step(input stim_t s, output res_t o, output res_t e);
    model_access(s, e);
    run_access(s, o);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.cpu_done, bus.cpu_hit, bus.cpu_error, bus.cpu_busy, bus.mem_write_enable,
         bus.mem_read_enable} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {bus.cpu_done, bus.cpu_hit,
        bus.cpu_error, bus.cpu_busy, bus.mem_write_enable, bus.mem_read_enable});
    end
    n_checks++;
    if ({bus.mem_adress, bus.mem_data_in, bus.cpu_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got adress=%h data_in=%h rdata=%h expected 0",
                         bus.mem_adress, bus.mem_data_in, bus.cpu_rdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.cpu_done, bus.cpu_busy, bus.mem_write_enable, bus.mem_read_enable} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 0000", {bus.cpu_done,
        bus.cpu_busy, bus.mem_write_enable, bus.mem_read_enable});
    end
  endtask

  task automatic test_write_miss();
    res_t o, e;
    do_step(mk(1'b1, 4'd2, 32'hAAAA, 1'b1, 1'b0), o, e);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL write_miss: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_read_miss_hit();
    res_t o, e;
    for (int i = 0; i < 2; i++) begin
      do_step(mk(1'b0, 4'd2, 32'h0, 1'b1, 1'b0), o, e);
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL read_miss_hit[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_write_through();
    res_t  o, e;
    stim_t q[$];
    q.push_back(mk(1'b1, 4'd2, 32'h1234, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 4'd2, 32'h0, 1'b1, 1'b0));
    foreach (q[i]) begin
      do_step(q[i], o, e);
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL write_through[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
    n_checks++;
    if (ram[2] !== 32'h1234) begin
      n_fail++; $display("FAIL ram_write_through: got %h expected 00001234", ram[2]);
    end
  endtask

  task automatic test_no_allocate_evict();
    res_t  o, e;
    stim_t q[$];
    q.push_back(mk(1'b1, 4'd6, 32'hBBBB, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 4'd6, 32'h0, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 4'd2, 32'h0, 1'b1, 1'b0));
    foreach (q[i]) begin
      do_step(q[i], o, e);
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL no_allocate_evict[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_timeout();
    res_t  o, e;
    stim_t q[$];
    q.push_back(mk(1'b0, 4'd3, 32'h0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 4'd3, 32'h0, 1'b1, 1'b0));
    foreach (q[i]) begin
      do_step(q[i], o, e);
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL timeout[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    res_t o, e;
    bit   seen_done = 0;
    do_step(mk(1'b0, 4'd5, 32'h0, 1'b1, 1'b0), o, e);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL mid_reset_fill: got %s, expected %s", fmt(o), fmt(e)); end
    @(negedge clk);
    ram_ok = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'd8;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.mem_read_enable !== 1'b1) begin
      n_fail++; $display("FAIL rd_wait_enable: got %b expected 1", bus.mem_read_enable);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_read_enable, bus.cpu_busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_drop_enable: got re=%b busy=%b expected 0 0",
                         bus.mem_read_enable, bus.cpu_busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.cpu_done) seen_done = 1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.cpu_done) seen_done = 1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL aborted_done: got 1 expected 0"); end
    for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
    ref_rdata = '0;
    do_step(mk(1'b0, 4'd5, 32'h0, 1'b1, 1'b0), o, e);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reread_after_reset: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_random();
    res_t  o, e;
    stim_t s;
    for (int i = 0; i < 40; i++) begin
      s = mk(1'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 7) != 0),
             1'($urandom));
      do_step(s, o, e);
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL random[%0d] addr=%0d we=%b: got %s, expected %s", i, s.addr, s.we,
                           fmt(o), fmt(e));
      end
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ram[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL ram_contents[%0d]: got %h expected %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hD00D_0000 + 32'(i) * 32'h0101_0011;
    for (int i = 0; i < 4; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = 0; ref_data[i] = '0; end
    ref_rdata = '0;
    test_reset();
    test_write_miss();
    test_read_miss_hit();
    test_write_through();
    test_no_allocate_evict();
    test_timeout();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate cache controller; the requesting side of the Ram interface. Accepts single-word CPU read/write requests and serves read hits from internal line storage. Misses and all writes are forwarded to the Ram block over its data_in/adress/write_enable/read_enable/data_out/valid_out interface. Sits between the CPU-side request port and the Ram instance in the caching system top level.

Parameters:
WIDTH, 32, data word width; matches Ram WIDTH.
DEPTH, 4, address width in bits (2**DEPTH words); matches Ram DEPTH.
INDEX_BITS, 2, cache index width; 2**INDEX_BITS lines, one word each; tag width = DEPTH-INDEX_BITS (>=1).
TIMEOUT, 15, max RD_WAIT cycles before the read is failed; counter width = clog2(TIMEOUT+1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_req  in  1  request strobe; sampled only in IDLE.
cpu_we  in  1  1=write, 0=read.
cpu_addr  in  DEPTH  word address.
cpu_wdata  in  WIDTH  write data.
cpu_rdata  out  WIDTH  read data; registered, held until next accepted request.
cpu_done  out  1  one-cycle completion pulse.
cpu_hit  out  1  registered; 1 if the completed access hit a valid line.
cpu_error  out  1  registered; 1 if the completed read timed out.
cpu_busy  out  1  high in every state except IDLE.
mem_adress  out  DEPTH  Ram address.
mem_data_in  out  WIDTH  Ram write data.
mem_write_enable  out  1  Ram write strobe.
mem_read_enable  out  1  Ram read enable.
mem_data_out  in  WIDTH  Ram read data.
mem_valid_out  in  1  Ram read-data valid, registered by Ram one edge after read_enable is sampled.

Behaviour:
- Storage per line: valid bit, tag, WIDTH-bit data. Index = cpu_addr[INDEX_BITS-1:0]; tag = upper bits.
- Reset (async): state IDLE; all valid bits 0; all outputs 0; timeout counter 0. Reset mid-operation aborts the access; mem enables drop immediately; no cpu_done for the aborted access.
- mem_* outputs are decoded only from state and latched request registers; no combinational path from cpu_* inputs. mem_adress/mem_data_in are 0 in IDLE.
- IDLE: on cpu_req=1, latch addr/we/wdata -> LOOKUP. cpu_req outside IDLE is ignored, not queued.
- LOOKUP: hit = valid && tag match.
  - Read hit: load cpu_rdata from line, cpu_hit=1, cpu_error=0 -> RESP.
  - Read miss -> RD_REQ.
  - Write: on hit, update line data at this edge. Record hit flag -> WR_MEM. A write miss does not allocate.
- WR_MEM: mem_write_enable=1, mem_adress=latched addr, mem_data_in=latched wdata for exactly one cycle -> RESP; cpu_hit=recorded flag, cpu_error=0.
- RD_REQ: mem_read_enable=1, mem_adress=addr; clear counter -> RD_WAIT.
- RD_WAIT: keep mem_read_enable=1 and mem_adress. mem_valid_out is only trusted here; Ram has sampled read_enable at least once.
  - If mem_valid_out=1: fill line (valid=1, tag, mem_data_out), cpu_rdata=mem_data_out, cpu_hit=0, cpu_error=0 -> RESP.
  - Else increment counter. On reaching TIMEOUT: cpu_error=1, cpu_hit=0, cpu_rdata unchanged, line untouched -> RESP.
- RESP: cpu_done=1 for one cycle, mem enables 0 -> IDLE. This guarantees >=1 cycle with read_enable low between Ram reads, so stale valid_out is never captured.
- Latency, in cycles from the req-sampling edge to cpu_done high:
  - read hit: 2.
  - write: 3.
  - read miss against a 1-cycle Ram: 4.
  - timeout: 3+TIMEOUT.
- Write to an index holding a different tag: line unchanged. Read miss to an occupied index: the line is replaced.

Test Plan:
1. Reset; write 0xAAAA to addr 2 -> one-cycle mem_write_enable with mem_adress=2, mem_data_in=0xAAAA; cpu_done 3 cycles after req; cpu_hit=0.
2. Read addr 2 -> miss: mem_read_enable with adress 2, cpu_rdata=0xAAAA, cpu_hit=0, done at 4 cycles. Repeat read -> cpu_hit=1, 0xAAAA, done at 2 cycles, no mem_read_enable.
3. Write 0x1234 to addr 2 (hit) -> cpu_hit=1, Ram write issued. Read addr 2 -> hit, 0x1234, Ram still holds 0x1234 (write-through).
4. Write 0xBBBB to addr 6 (index 2, tag 1) -> miss, no allocate. Read 6 -> miss, 0xBBBB, line evicted. Read 2 -> miss, 0x1234.
5. Ram model holds mem_valid_out=0 -> cpu_error=1, cpu_done 3+15 cycles after req, mem_read_enable drops in RESP. Re-read the same addr with a normal model -> miss, correct data.
6. Assert reset during RD_WAIT -> mem_read_enable=0 immediately, no cpu_done. After release, a read of a previously cached addr -> cpu_hit=0.
